// File: rtl/regfile_dual_hilo.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dual_hilo
// Brief    : 2**ADDR_W x DATA_W general-purpose register file for the
//            dual-issue pipeline. It has two commit write ports, four
//            combinational operand-fetch read ports and the HI/LO pair.
//            Slot 1 is the older instruction and slot 2 the younger one, so
//            slot 2 wins a same-address write. Register 0 always reads 0.
// Options  : REGFILE_WRITE_BYPASS_EN - same-cycle write-to-read bypass for
//            the GPR read ports and for HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dual_hilo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  // commit write ports (slot 1 older, slot 2 younger)
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] waddr2,
  input  logic [DATA_W-1:0] wdata2,
  // operand-fetch read ports (1/2: instruction 1, 3/4: instruction 2)
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              re3,
  input  logic [ADDR_W-1:0] raddr3,
  output logic [DATA_W-1:0] rdata3,
  input  logic              re4,
  input  logic [ADDR_W-1:0] raddr4,
  output logic [DATA_W-1:0] rdata4,
  // HI/LO pair
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int c_num_regs = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [c_num_regs];
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  // Resolve one read port: reset, disable and r0 force zero; then the
  // optional bypass (younger slot first), otherwise the stored value.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              re,
    input logic [ADDR_W-1:0] raddr
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (!rst && re && (raddr != '0)) begin
`ifdef REGFILE_WRITE_BYPASS_EN
      if (we2 && (waddr2 == raddr)) begin
        v = wdata2;
      end else if (we1 && (waddr1 == raddr)) begin
        v = wdata1;
      end else begin
        v = r_regs[raddr];
      end
`else
      v = r_regs[raddr];
`endif
    end
    return v;
  endfunction

  // GPR array: reset clears all entries; slot 2 is applied after slot 1 so
  // the younger write wins a collision. Writes to r0 are dropped, so r0
  // stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_num_regs; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (we1 && (waddr1 != '0)) begin
        r_regs[waddr1] <= wdata1;
      end
      if (we2 && (waddr2 != '0)) begin
        r_regs[waddr2] <= wdata2;
      end
    end
  end

  // HI/LO pair: both registers always update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (whilo) begin
      r_hi <= hi_i;
      r_lo <= lo_i;
    end
  end

  // Four independent combinational read ports.
  always_comb begin
    rdata1 = read_port(re1, raddr1);
    rdata2 = read_port(re2, raddr2);
    rdata3 = read_port(re3, raddr3);
    rdata4 = read_port(re4, raddr4);
  end

  // HI/LO outputs: forced to zero in reset, with an optional same-cycle bypass.
  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (!rst) begin
      hi_o = r_hi;
      lo_o = r_lo;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (whilo) begin
        hi_o = hi_i;
        lo_o = lo_i;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/regfile_dual_hilo.md
Name: regfile_dual_hilo

Overview:
- Architectural state owner for the dual-issue pipeline: 32x32 GPR file with two commit-side write ports, four operand-fetch read ports, plus the HI/LO register pair.
- It is the responder that the operand-fetch stage reads. Commit drives the write ports and HI/LO update in program order: slot 1 is older, slot 2 is younger.
- Reads are combinational so operand fetch can forward in the same cycle. Writes and HI/LO update on the clock edge.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register address width; register count is 2**ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- we1  in  1  write enable, slot 1 (older instruction).
- waddr1  in  ADDR_W  write address, slot 1.
- wdata1  in  DATA_W  write data, slot 1.
- we2  in  1  write enable, slot 2 (younger instruction).
- waddr2  in  ADDR_W  write address, slot 2.
- wdata2  in  DATA_W  write data, slot 2.
- re1..re4  in  1 each  read enables; 1/2 serve instruction 1 operands, 3/4 serve instruction 2 operands.
- raddr1..raddr4  in  ADDR_W each  read addresses.
- rdata1..rdata4  out  DATA_W each  read data, combinational.
- whilo  in  1  HI/LO write enable from commit.
- hi_i  in  DATA_W  new HI value.
- lo_i  in  DATA_W  new LO value.
- hi_o  out  DATA_W  current HI value.
- lo_o  out  DATA_W  current LO value.

Behaviour:
- Storage: regs[0..2**ADDR_W-1] and hi_q/lo_q, all flops.
- Reset: rising edge with rst=1 clears every regs[i], hi_q and lo_q to 0. Reset beats any write or whilo asserted in the same cycle.
- Reset outputs: while rst=1, rdata1..4, hi_o and lo_o are forced to 0 combinationally.
- Write, rst=0, rising edge:
  - if we1=1 and waddr1!=0, regs[waddr1]<=wdata1;
  - if we2=1 and waddr2!=0, regs[waddr2]<=wdata2.
- Same-address collision (we1=we2=1, waddr1==waddr2!=0): wdata2 is stored. Younger wins.
- Register 0 is hardwired to 0. Writes to it are dropped; reads of it return 0 regardless of bypass.
- Write latency: a write committed at edge N is visible from the array in cycle N+1.
- HI/LO: at a rising edge with rst=0 and whilo=1, hi_q<=hi_i and lo_q<=lo_i. Both update together, never singly. When whilo=0 they hold.
- Read port k, combinational, priority order:
  1. rst=1 -> 0
  2. re_k=0 -> 0
  3. raddr_k==0 -> 0
  4. bypass hit (only when macro defined, see Optional Feature)
  5. otherwise regs[raddr_k]
- All four ports are independent. Any number of ports may read the same address in the same cycle.
- hi_o/lo_o: hi_q/lo_q, except when rst=1 (0) or when the HI/LO bypass applies under the macro.
- X-safety: wdata is never sampled when we=0, so X on wdata with we=0 must not corrupt the array.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: same-cycle write-to-read bypass.
  - For read port k (after the rst/re/zero checks): if we2=1 and waddr2==raddr_k, return wdata2; else if we1=1 and waddr1==raddr_k, return wdata1; else return the array value.
  - If whilo=1, hi_o=hi_i and lo_o=lo_i combinationally.
  - Bypass is ignored while rst=1.
- Undefined: reads return the stored array/hi_q/lo_q values only. Same-cycle writes become visible next cycle, and operand fetch must cover that window through forwarding.

Test Plan:
- Reset sweep: pulse rst for 1 cycle after writing 0xDEADBEEF to r5 and whilo with hi_i=1, lo_i=2 -> next cycle, with re1=1 and raddr1=5, rdata1=0; hi_o=lo_o=0.
- Dual write, different addresses: we1 to r3 with 0x11111111, we2 to r4 with 0x22222222 -> next cycle rdata1(r3)=0x11111111 and rdata3(r4)=0x22222222.
- Collision: we1 and we2 both to r7, wdata1=0xAAAA0000, wdata2=0x0000BBBB -> next cycle rdata2=0x0000BBBB. With the macro, rdata2 already shows 0x0000BBBB in the write cycle.
- r0 and read disable: we1 to r0 with 0xFFFFFFFF, then read r0 on all four ports -> all 0. Read r3 with re1=0 -> rdata1=0.
- Reset precedence: rst=1 with we1 to r9 = 0x12345678 and whilo=1 -> after the edge r9=0 and hi_o=lo_o=0. A write to r9 in the following cycle takes effect normally.
- HI/LO hold and update: whilo=1 with hi_i=0xCAFE0001, lo_i=0xBEEF0002, then whilo=0 for 3 cycles with hi_i=lo_i=0 -> hi_o/lo_o stay 0xCAFE0001/0xBEEF0002. Without the macro they change only after the edge.
